// File: rtl/matrix_packer_writer.sv
// matrix_packer_writer: packs LANES elements of ELEM_W bits into each block-RAM word and writes them sequentially.
// Optional running checksum output enabled by defining PACKER_CHECKSUM_EN.
module matrix_packer_writer #(
   parameter int ELEM_W = 16,
   parameter int LANES  = 3,
   parameter int ADDR_W = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [ELEM_W-1:0]         s_data,
   input  logic                      s_last,
   output logic                      mem_ena,
   output logic                      mem_wea,
   output logic [ADDR_W-1:0]         mem_addra,
   output logic [ELEM_W*LANES-1:0]   mem_dina,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
`ifdef PACKER_CHECKSUM_EN
   ,
   output logic [31:0]               checksum
`endif
);
   localparam int W  = ELEM_W * LANES;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [W-1:0]      pack_q, pack_d;
   logic              last_q, last_d;
   logic              ovf_q, ovf_d;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lane_q  <= '0;
         pack_q  <= '0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         pack_q  <= pack_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      lane_d   = lane_q;
      pack_d   = pack_q;
      last_d   = last_q;
      ovf_d    = ovf_q;
      s_ready  = 1'b0;
      mem_ena  = 1'b0;
      mem_wea  = 1'b0;
      mem_dina = '0;
      done     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = FILL;
            addr_d  = '0;
            lane_d  = '0;
            pack_d  = '0;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
         end
         FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               // lane 0 lands in the most significant slice
               pack_d[ELEM_W*(LANES-1-int'(lane_q)) +: ELEM_W] = s_data;
               lane_d = lane_q + 1'b1;
               last_d = s_last;
               state_d = (s_last || lane_q == LW'(LANES-1)) ? WRITE : FILL;
            end
         end
         WRITE: begin
            mem_ena  = 1'b1;
            mem_wea  = 1'b1;
            mem_dina = pack_q;
            pack_d   = '0;
            lane_d   = '0;
            addr_d   = addr_q + 1'b1;
            ovf_d    = ovf_q | (!last_q && &addr_q);
            state_d  = (last_q || &addr_q) ? DONE : FILL;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign mem_addra = addr_q;
   assign busy      = state_q != IDLE;
   assign overflow  = ovf_q;
`ifdef PACKER_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
   always_comb begin
      csum_d = (state_q == IDLE && start) ? 32'd0 :
               (state_q == FILL && s_valid) ? csum_q + 32'(s_data) : csum_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) csum_q <= '0;
      else          csum_q <= csum_d;
   end
   assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_matrix_packer_writer.sv
// tb_matrix_packer_writer: table-driven image loads with a write scoreboard, plus reset and start-ignore sequences.
module tb_matrix_packer_writer;
   localparam int EW = 16;
   localparam int LN = 3;
   localparam int AW = 2;
   localparam int DW = EW * LN;
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic [EW-1:0] s_data = '0;
   logic          s_ready, mem_ena, mem_wea, busy, done, overflow;
   logic [AW-1:0] mem_addra;
   logic [DW-1:0] mem_dina;
`ifdef PACKER_CHECKSUM_EN
   logic [31:0]   checksum;
`endif
   always #5 clk = ~clk;
   matrix_packer_writer #(.ELEM_W(EW), .LANES(LN), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
      .busy(busy), .done(done), .overflow(overflow)
`ifdef PACKER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );
   int passed = 0;
   int total = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endtask
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;
   wr_t sb[$];
   logic [DW-1:0] img[4];
   int wr_cnt = 0;
   int done_cnt = 0;
   int strobe_err = 0;
   logic [31:0] csum_at_done = '0;
   always @(negedge clk) begin
      if (mem_wea) begin
         wr_cnt++;
         img[mem_addra] = mem_dina;
         if (sb.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", mem_addra, mem_dina);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", mem_addra, e.a);
            chk("wr_data", mem_dina, e.d);
            chk("wr_ena", mem_ena, 1);
         end
      end else if (mem_ena || mem_dina != '0) strobe_err++;
      if (done) begin
         done_cnt++;
`ifdef PACKER_CHECKSUM_EN
         csum_at_done = checksum;
`endif
      end
   end
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask
   // offers one element, optionally after an idle valid cycle; acc reports whether it was taken
   task automatic send(input logic [EW-1:0] d, input logic last, input logic gap, output logic acc);
      acc = 1'b0;
      if (gap) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data = d;
      s_last = last;
      for (int c = 0; c < 8 && !acc; c++) begin
         @(negedge clk);
         if (s_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask
   task automatic wait_done(input int dn0);
      for (int c = 0; c < 30 && done_cnt == dn0; c++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask
   typedef struct {
      int            n;
      logic          last;
      logic          gap;
      logic [EW-1:0] base;
      logic [EW-1:0] step;
      int            exp_wr;
      logic          exp_ovf;
      int            exp_acc;
      logic [AW-1:0] exp_addr;
   } vec_t;
   vec_t vt[5];
   task automatic run_image(input vec_t v);
      logic [DW-1:0] w;
      logic [AW-1:0] a;
      logic [EW-1:0] d;
      logic [31:0]   sum;
      logic          acc, lst, stop;
      int            lane, nacc, wr0, dn0;
      w = '0; a = '0; sum = '0; stop = 1'b0; lane = 0; nacc = 0;
      wr0 = wr_cnt; dn0 = done_cnt;
      pulse_start();
      for (int k = 0; k < v.n; k++) begin
         d = v.base + 16'(k) * v.step;
         lst = v.last && (k == v.n - 1);
         send(d, lst, v.gap, acc);
         chk("accept", acc, !stop);
         if (acc) begin
            nacc++;
            sum += 32'(d);
            w[EW*(LN-1-lane) +: EW] = d;
            lane++;
            if (lane == LN || lst) begin
               sb.push_back('{a, w});
               if (!lst && a == AW'(3)) stop = 1'b1;
               a++;
               w = '0;
               lane = 0;
            end
         end
      end
      wait_done(dn0);
      chk("done_pulses", done_cnt - dn0, 1);
      chk("writes", wr_cnt - wr0, v.exp_wr);
      chk("accepted", nacc, v.exp_acc);
      chk("overflow", overflow, v.exp_ovf);
      chk("sb_empty", sb.size(), 0);
      chk("busy_idle", busy, 0);
      chk("addr_hold", mem_addra, v.exp_addr);
`ifdef PACKER_CHECKSUM_EN
      chk("checksum", csum_at_done, sum);
`endif
      sb.delete();
   endtask
   initial begin
      logic acc;
      int   wr0, dn0;
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic acc;
      int   wr0, dn0;
      vt[0] = '{12, 1'b1, 1'b0, 16'h0001, 16'h0001, 4, 1'b0, 12, 2'd0};
      vt[1] = '{4,  1'b1, 1'b0, 16'h1111, 16'h1111, 2, 1'b0, 4,  2'd2};
      vt[2] = '{13, 1'b0, 1'b0, 16'h0100, 16'h0001, 4, 1'b1, 12, 2'd0};
      vt[3] = '{12, 1'b1, 1'b1, 16'h0001, 16'h0001, 4, 1'b0, 12, 2'd0};
      vt[4] = '{5,  1'b1, 1'b1, 16'hA000, 16'h0101, 2, 1'b0, 5,  2'd2};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {s_ready, mem_ena, mem_wea, mem_addra, mem_dina, busy, done, overflow}, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_image(vt[i]);
         if (i == 0 || i == 3) begin
            chk("img_addr0", img[0], 48'h0001_0002_0003);
            chk("img_addr1", img[1], 48'h0004_0005_0006);
            chk("img_addr2", img[2], 48'h0007_0008_0009);
            chk("img_addr3", img[3], 48'h000A_000B_000C);
`ifdef PACKER_CHECKSUM_EN
            chk("checksum_12", csum_at_done, 32'h0000_004E);
`endif
         end
         if (i == 1) begin
            chk("img_short0", img[0], 48'h1111_2222_3333);
            chk("img_short1", img[1], 48'h4444_0000_0000);
         end
      end
      // reset mid-word: partial word abandoned, reload starts at address 0
      pulse_start();
      send(16'hAAAA, 1'b0, 1'b0, acc);
      send(16'hBBBB, 1'b0, 1'b0, acc);
      wr0 = wr_cnt;
      reset_n = 1'b0;
      #1;
      chk("rst_async_outputs", {s_ready, mem_ena, mem_wea, mem_addra, mem_dina, busy, done, overflow}, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_no_write", wr_cnt - wr0, 0);
      sb.push_back('{2'd0, 48'h0C01_0C02_0C03});
      dn0 = done_cnt;
      pulse_start();
      send(16'h0C01, 1'b0, 1'b0, acc);
      send(16'h0C02, 1'b0, 1'b0, acc);
      send(16'h0C03, 1'b1, 1'b0, acc);
      wait_done(dn0);
      chk("rst_reload_writes", wr_cnt - wr0, 1);
      chk("rst_reload_img", img[0], 48'h0C01_0C02_0C03);
      chk("rst_reload_sb", sb.size(), 0);
      // start while filling must not restart the word
      sb.delete();
      sb.push_back('{2'd0, 48'h0D01_0D02_0D03});
      wr0 = wr_cnt;
      dn0 = done_cnt;
      pulse_start();
      send(16'h0D01, 1'b0, 1'b0, acc);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      send(16'h0D02, 1'b0, 1'b0, acc);
      send(16'h0D03, 1'b1, 1'b0, acc);
      wait_done(dn0);
      chk("start_ignored_writes", wr_cnt - wr0, 1);
      chk("start_ignored_img", img[0], 48'h0D01_0D02_0D03);
      chk("start_ignored_addr", mem_addra, 2'd1);
      chk("idle_strobes", strobe_err, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
